// File: rtl/mac_channel_sequencer.sv
// Sequences one image row through the MAC: for every column and output channel it
// streams all input channels, waits for the accumulation and hands the tagged result out.
module mac_channel_sequencer #(
    parameter int IN_CHANNELS  = 4,
    parameter int OUT_CHANNELS = 8,
    parameter int IMAGE_WIDTH  = 188,
    parameter int DATA_WIDTH   = 16,
    parameter int DONE_TIMEOUT = 64,
    localparam int CH_W  = (IN_CHANNELS  > 1) ? $clog2(IN_CHANNELS)  : 1,
    localparam int OC_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
    localparam int TMO_W = $clog2(DONE_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         job_start,
    input  logic                         win_valid,
    output logic                         win_consume,
    output logic [CH_W-1:0]              ch_sel,
    output logic [OC_W-1:0]              oc_sel,
    output logic [DATA_WIDTH-1:0]        col_idx,
    output logic                         mac_start,
    input  logic                         mac_done,
    input  logic signed [DATA_WIDTH-1:0] mac_result,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [OC_W-1:0]              out_oc,
    output logic [DATA_WIDTH-1:0]        out_col,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         job_done,
    output logic                         timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_WIN, S_ISSUE, S_WAIT_DONE, S_EMIT, S_ERROR
    } state_t;

    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(IN_CHANNELS - 1);
    localparam logic [OC_W-1:0]       OC_LAST  = OC_W'(OUT_CHANNELS - 1);
    localparam logic [DATA_WIDTH-1:0] COL_LAST = DATA_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

    state_t                         state_q, state_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic [OC_W-1:0]                oc_q, oc_d;
    logic [DATA_WIDTH-1:0]          col_q, col_d;
    logic [TMO_W-1:0]               tmo_q, tmo_d;
    logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [OC_W-1:0]                out_oc_q, out_oc_d;
    logic [DATA_WIDTH-1:0]          out_col_q, out_col_d;
    logic                           timeout_err_q, timeout_err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ch_q          <= '0;
            oc_q          <= '0;
            col_q         <= '0;
            tmo_q         <= '0;
            out_data_q    <= '0;
            out_oc_q      <= '0;
            out_col_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ch_q          <= ch_d;
            oc_q          <= oc_d;
            col_q         <= col_d;
            tmo_q         <= tmo_d;
            out_data_q    <= out_data_d;
            out_oc_q      <= out_oc_d;
            out_col_q     <= out_col_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        oc_d          = oc_q;
        col_d         = col_q;
        tmo_d         = tmo_q;
        out_data_d    = out_data_q;
        out_oc_d      = out_oc_q;
        out_col_d     = out_col_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    col_d   = '0;
                    oc_d    = '0;
                    state_d = S_WAIT_WIN;
                end
            end
            S_WAIT_WIN: begin
                if (win_valid) begin
                    ch_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ch_sel stays on the last channel while the MAC drains
                if (ch_q == CH_LAST) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (mac_done) begin
                    out_data_d = mac_result;
                    out_oc_d   = oc_q;
                    out_col_d  = col_q;
                    state_d    = S_EMIT;
                end else if (tmo_q == TMO_LAST) begin
                    ch_d          = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (oc_q != OC_LAST) begin
                        oc_d    = oc_q + OC_W'(1);
                        state_d = S_WAIT_WIN;
                    end else if (col_q == COL_LAST) begin
                        oc_d    = '0;
                        col_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        oc_d    = '0;
                        col_d   = col_q + DATA_WIDTH'(1);
                        state_d = S_WAIT_WIN;
                    end
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        mac_start   = (state_q == S_ISSUE) && (ch_q == '0);
        out_valid   = (state_q == S_EMIT);
        win_consume = (state_q == S_EMIT) && out_ready && (oc_q == OC_LAST);
        job_done    = win_consume && (col_q == COL_LAST);
    end

    assign ch_sel      = ch_q;
    assign oc_sel      = oc_q;
    assign col_idx     = col_q;
    assign out_data    = out_data_q;
    assign out_oc      = out_oc_q;
    assign out_col     = out_col_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mac_channel_sequencer.sv
// Scoreboard bench for mac_channel_sequencer: expected results come from a row-level
// model pushed at job start; a negedge monitor pops them on every output transfer.
module tb_mac_channel_sequencer;

    localparam int IC = 4;
    localparam int OC = 2;
    localparam int W = 3;
    localparam int DW = 16;
    localparam int TMO = 64;
    localparam int MAC_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic job_start = 1'b0;
    logic win_valid = 1'b0;
    logic mac_done = 1'b0;
    logic out_ready = 1'b0;
    logic signed [DW-1:0] mac_result = '0;
    logic win_consume, mac_start, out_valid, busy, job_done, timeout_err;
    logic [1:0] ch_sel;
    logic [0:0] oc_sel, out_oc;
    logic [DW-1:0] col_idx, out_col;
    logic signed [DW-1:0] out_data;

    mac_channel_sequencer #(
        .IN_CHANNELS(IC), .OUT_CHANNELS(OC), .IMAGE_WIDTH(W),
        .DATA_WIDTH(DW), .DONE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .job_start(job_start), .win_valid(win_valid),
        .win_consume(win_consume), .ch_sel(ch_sel), .oc_sel(oc_sel), .col_idx(col_idx),
        .mac_start(mac_start), .mac_done(mac_done), .mac_result(mac_result),
        .out_data(out_data), .out_oc(out_oc), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .job_done(job_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            oc;
        int            col;
    } res_t;
    res_t exp_q[$];

    // Reference: a row yields every (col, oc) pair, oc fastest, with the MAC's tag value.
    task automatic push_job();
        for (int c = 0; c < W; c++)
            for (int o = 0; o < OC; o++) begin
                res_t r;
                r.data = DW'(16'h1000 + o * 16 + c);
                r.oc = o;
                r.col = c;
                exp_q.push_back(r);
            end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MAC model: done one cycle, MAC_LAT cycles after the last channel.
    int done_at = -1;
    logic [DW-1:0] pend_res = '0;
    bit mac_dead = 0;
    always @(posedge clk) begin
        #1;
        mac_done = (!mac_dead && cyc == done_at);
        mac_result = mac_done ? pend_res : '0;
    end

    bit rand_mode = 0;
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            win_valid = ($urandom_range(0, 2) != 0);
        end
    end

    int n_xfer = 0, n_consume = 0, n_jd = 0, n_start = 0;
    int pos = 0;
    bit prev_stall = 0;
    logic [63:0] prev_payload = '0;

    always @(negedge clk) begin
        if (!rst) begin
            pos = 0;
            prev_stall = 0;
            done_at = -1;
        end else begin
            if (mac_start) begin
                n_start++;
                done_at = cyc + (IC - 1) + MAC_LAT;
                pend_res = DW'(16'h1000 + int'(oc_sel) * 16 + int'(col_idx));
            end
            if (win_consume) n_consume++;
            if (job_done) n_jd++;
            if (mac_start) begin
                check("ch_sel_at_start", 64'(ch_sel), 0);
                pos = 1;
            end else if (pos != 0 && pos < IC) begin
                check("ch_sel_seq", 64'(ch_sel), 64'(pos));
                pos++;
            end else begin
                pos = 0;
            end
            if (out_valid) check("no_start_in_emit", 64'(mac_start), 0);
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 1);
                check("hold_payload", 64'({out_data, out_oc, out_col}), prev_payload);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got col=%0d oc=%0d data=0x%0h, expected none",
                             out_col, out_oc, out_data);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("result_data", 64'(out_data), 64'(e.data));
                    check("result_oc", 64'(out_oc), 64'(e.oc));
                    check("result_col", 64'(out_col), 64'(e.col));
                    n_xfer++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_payload = 64'({out_data, out_oc, out_col});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_xfer = 0; n_consume = 0; n_jd = 0; n_start = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_job_done"}, 64'(job_done), 0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 0);
        check({tag, "_mac_start"}, 64'(mac_start), 0);
        check({tag, "_win_consume"}, 64'(win_consume), 0);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_out_data"}, 64'(out_data), 0);
        check({tag, "_out_oc"}, 64'(out_oc), 0);
        check({tag, "_out_col"}, 64'(out_col), 0);
        check({tag, "_col_idx"}, 64'(col_idx), 0);
        check({tag, "_ch_sel"}, 64'(ch_sel), 0);
        check({tag, "_oc_sel"}, 64'(oc_sel), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        job_start = 1'b0;
        repeat (2) tick();
        check_idle(tag);
        exp_q.delete();
        rst = 1'b1;
        tick();
    endtask

    task automatic start_job();
        tick();
        job_start = 1'b1;
        push_job();
        tick();
        job_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (job_done) begin
                seen = 1;
                break;
            end
        end
        check(name, 64'(seen), 1);
        repeat (3) tick();
    endtask

    initial begin
        bit seen;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b1;
        tick();

        // Full row with everything ready
        clr_counts();
        win_valid = 1'b1;
        out_ready = 1'b1;
        start_job();
        wait_done("A_job_done", 400);
        check("A_results", 64'(n_xfer), 6);
        check("A_consumes", 64'(n_consume), 3);
        check("A_job_dones", 64'(n_jd), 1);
        check("A_mac_starts", 64'(n_start), 6);
        check("A_queue_empty", 64'(exp_q.size()), 0);
        check("A_idle", 64'(busy), 0);

        // Backpressure on the first result
        clr_counts();
        out_ready = 1'b0;
        start_job();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check("B_first_valid", 64'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("B_stall_valid", 64'(out_valid), 1);
            check("B_stall_data", 64'(out_data), 64'h1000);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("B_xfer_valid", 64'(out_valid), 1);
        check("B_xfer_no_consume", 64'(win_consume), 0);
        @(negedge clk);
        check("B_valid_dropped", 64'(out_valid), 0);
        wait_done("B_job_done", 400);
        check("B_results", 64'(n_xfer), 6);
        check("B_job_dones", 64'(n_jd), 1);

        // Window not ready before column 1
        clr_counts();
        win_valid = 1'b1;
        start_job();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (win_consume) begin
                seen = 1;
                break;
            end
        end
        check("C_first_consume", 64'(seen), 1);
        win_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("C_wait_no_start", 64'(mac_start), 0);
            check("C_wait_busy", 64'(busy), 1);
        end
        check("C_wait_col", 64'(col_idx), 1);
        tick();
        win_valid = 1'b1;
        @(negedge clk);
        check("C_resume_not_yet", 64'(mac_start), 0);
        @(negedge clk);
        check("C_resume_start", 64'(mac_start), 1);
        wait_done("C_job_done", 400);
        check("C_results", 64'(n_xfer), 6);

        // Randomized handshakes over several rows
        rand_mode = 1;
        for (int j = 0; j < 3; j++) begin
            clr_counts();
            start_job();
            wait_done("D_job_done", 2000);
            check("D_results", 64'(n_xfer), 6);
            check("D_queue_empty", 64'(exp_q.size()), 0);
        end
        rand_mode = 0;
        repeat (2) tick();

        // MAC never completes
        win_valid = 1'b1;
        out_ready = 1'b1;
        mac_dead = 1;
        clr_counts();
        start_job();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mac_start) begin
                seen = 1;
                break;
            end
        end
        check("E_mac_start", 64'(seen), 1);
        repeat (IC + TMO - 1) @(negedge clk);
        check("E_err_before", 64'(timeout_err), 0);
        @(negedge clk);
        check("E_err_set", 64'(timeout_err), 1);
        check("E_err_busy", 64'(busy), 1);
        tick();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        repeat (5) @(negedge clk);
        check("E_sticky", 64'(timeout_err), 1);
        check("E_still_busy", 64'(busy), 1);
        check("E_no_restart", 64'(n_start), 1);
        check("E_no_valid", 64'(out_valid), 0);
        tick();
        do_reset("E_reset");
        mac_dead = 0;

        // Reset during column 1 issue, then a fresh row
        clr_counts();
        start_job();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mac_start && col_idx == 1) begin
                seen = 1;
                break;
            end
        end
        check("F_col1_issue", 64'(seen), 1);
        tick();
        do_reset("F_reset");
        clr_counts();
        repeat (12) @(negedge clk);
        check("F_no_stale_xfer", 64'(n_xfer), 0);
        check("F_no_stale_done", 64'(n_jd), 0);
        start_job();
        wait_done("F_job_done", 400);
        check("F_results", 64'(n_xfer), 6);

        // job_start while busy has no effect
        clr_counts();
        start_job();
        for (int k = 0; k < 4; k++) begin
            repeat (7) tick();
            job_start = 1'b1;
            tick();
            job_start = 1'b0;
        end
        wait_done("G_job_done", 400);
        repeat (30) tick();
        check("G_job_dones", 64'(n_jd), 1);
        check("G_results", 64'(n_xfer), 6);
        check("G_idle", 64'(busy), 0);
        check("G_queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_channel_sequencer.md
MAC_CHANNEL_SEQUENCER -- requirements
Module: mac_channel_sequencer

Interface
REQ-001 SHALL have parameter IN_CHANNELS, default 4: input channels streamed into the MAC per output pixel.
REQ-002 SHALL have parameter OUT_CHANNELS, default 8: output channels (kernel sets) per window column.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 188: window columns per job.
REQ-004 SHALL have parameter DATA_WIDTH, default 16: Q2.14 result width.
REQ-005 SHALL have parameter DONE_TIMEOUT, default 64: maximum cycles to wait for mac_done.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port job_start, input, 1: one-cycle request to process one full row.
REQ-009 SHALL have port win_valid, input, 1: window buffer holds the window for col_idx.
REQ-010 SHALL have port win_consume, output, 1: one-cycle pulse telling the buffer to advance to the next column.
REQ-011 SHALL have port ch_sel, output, clog2(IN_CHANNELS): channel selecting the feature-map window and kernel driven into the MAC.
REQ-012 SHALL have port oc_sel, output, clog2(OUT_CHANNELS): output channel selecting the kernel set.
REQ-013 SHALL have port col_idx, output, DATA_WIDTH: current column; drives the MAC col_index_window.
REQ-014 SHALL have port mac_start, output, 1: MAC start pulse.
REQ-015 SHALL have port mac_done, input, 1: MAC accumulation complete.
REQ-016 SHALL have port mac_result, input, DATA_WIDTH signed: saturated MAC output.
REQ-017 SHALL have ports out_data (output, DATA_WIDTH signed), out_oc (output, clog2(OUT_CHANNELS)) and out_col (output, DATA_WIDTH): result tagged with its output channel and column.
REQ-018 SHALL have ports out_valid (output, 1) and out_ready (input, 1): valid/ready result handshake.
REQ-019 SHALL have ports busy (output, 1), job_done (output, 1 pulse) and timeout_err (output, 1 sticky).

Function
REQ-020 SHALL implement states IDLE, WAIT_WIN, ISSUE, WAIT_DONE, EMIT, ERROR.
REQ-021 IDLE: on job_start=1, SHALL clear col_idx and oc_sel, then go to WAIT_WIN; busy=1 in every state except IDLE.
REQ-022 WAIT_WIN: SHALL stay while win_valid=0 and go to ISSUE on win_valid=1; win_valid is sampled only here.
REQ-023 ISSUE SHALL last exactly IN_CHANNELS cycles with ch_sel=0..IN_CHANNELS-1, one channel per cycle; mac_start=1 only in the ch_sel=0 cycle.
REQ-024 After the last ISSUE cycle, SHALL enter WAIT_DONE, hold ch_sel at IN_CHANNELS-1 and clear the timeout counter.
REQ-025 WAIT_DONE: on mac_done=1, SHALL register mac_result, oc_sel and col_idx into out_data, out_oc and out_col, then go to EMIT; mac_done SHALL be ignored in all other states.
REQ-026 WAIT_DONE: if the counter reaches DONE_TIMEOUT with no mac_done, SHALL go to ERROR and set timeout_err=1.
REQ-027 EMIT: out_valid=1; out_data, out_oc and out_col SHALL be held stable until a cycle with out_valid=1 and out_ready=1 (transfer).
REQ-028 On transfer with oc_sel<OUT_CHANNELS-1: oc_sel SHALL increment and the state SHALL return to WAIT_WIN (same column).
REQ-029 On transfer with oc_sel=OUT_CHANNELS-1: win_consume SHALL pulse for that cycle, oc_sel SHALL clear and col_idx SHALL increment.
REQ-030 On that transfer, if col_idx=IMAGE_WIDTH-1, SHALL pulse job_done, clear col_idx and go to IDLE; otherwise SHALL go to WAIT_WIN.
REQ-031 Minimum per-result latency: 1 (WAIT_WIN) + IN_CHANNELS (ISSUE) + MAC latency + 1 (EMIT) cycles.
REQ-032 job_start SHALL be ignored outside IDLE.
REQ-033 ERROR SHALL be terminal until reset: outputs idle, busy=1, job_start ignored.
REQ-034 Counters SHALL never exceed their range; col_idx wraps only through REQ-030.

Reset
REQ-035 On rst=0 at a clock edge, in any state, SHALL enter IDLE with all outputs 0: busy, job_done, timeout_err, mac_start, win_consume, out_valid, out_data, out_oc, out_col, col_idx, ch_sel and oc_sel.
REQ-036 A reset mid-job SHALL discard any pending result; no out_valid or job_done follows until a new job_start.

Verification (IN_CHANNELS=4, OUT_CHANNELS=2, IMAGE_WIDTH=3; MAC model asserts done 3 cycles after its last channel, result=0x1000+oc*16+col)
REQ-037 SHALL verify: job_start, win_valid=1 and out_ready=1 constant -> 6 results in order (col,oc) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) with matching data; 3 win_consume pulses; 1 job_done; mac_start pulsed 6 times, each followed by ch_sel 0,1,2,3 on consecutive cycles.
REQ-038 SHALL verify: out_ready=0 for 10 cycles at first EMIT -> out_valid held with out_data=0x1000 stable, no new mac_start, transfer on the first ready cycle.
REQ-039 SHALL verify: win_valid=0 for 5 cycles before column 1 -> state held in WAIT_WIN, no mac_start; resumes 1 cycle after win_valid=1.
REQ-040 SHALL verify: MAC model never asserts done -> timeout_err=1 exactly DONE_TIMEOUT cycles into WAIT_DONE; later job_start ignored; rst=0 clears it.
REQ-041 SHALL verify: rst=0 during ISSUE of column 1, then job_start -> all outputs 0 after reset; new job restarts at (col,oc)=(0,0).
REQ-042 SHALL verify: job_start pulsed while busy -> no effect on sequence; exactly one job_done.
